// File: rtl/pe_pkg.sv
// ----------------------------------------------------------------------------
// pe_pkg
//   Shared types and helpers for the vector MAC processing element.
//   - pe_state_t : control FSM states
//   - PE_*       : default geometry for the datapath
//   - sat_add    : signed add clamped to a w-bit two's-complement range.
//                  Operands arrive sign-extended to 64 bits, so w <= 63.
// ----------------------------------------------------------------------------
package pe_pkg;

    typedef enum logic [1:0] {
        PE_IDLE  = 2'd0,
        PE_ACCUM = 2'd1,
        PE_PUSH  = 2'd2
    } pe_state_t;

    localparam int PE_DW    = 16;
    localparam int PE_LANES = 4;
    localparam int PE_ACC_W = 48;

    // Two w-bit values summed in 64 bits cannot overflow the 64-bit carrier,
    // so the clamp decision is exact.
    function automatic logic signed [63:0] sat_add(input logic signed [63:0] a,
                                                   input logic signed [63:0] b,
                                                   input int w);
        logic signed [63:0] one;
        logic signed [63:0] hi;
        logic signed [63:0] lo;
        logic signed [63:0] s;
        one = 64'sd1;
        hi  = (one <<< (w - 1)) - one;
        lo  = -hi - one;
        s   = a + b;
        if (s > hi)
            return hi;
        else if (s < lo)
            return lo;
        else
            return s;
    endfunction

endpackage

// File: rtl/pe_vector_mac_if.sv
// ----------------------------------------------------------------------------
// pe_vector_mac_if
//   Bundles the beat-input handshake and the result-FIFO read port.
//   master : upstream reader / downstream consumer side
//            drives active, vec_len, data_a, data_b, rd_en
//   slave  : processing element side
//            drives in_ready, out_empty, out_full, out_data
// ----------------------------------------------------------------------------
interface pe_vector_mac_if #(
    parameter int DW    = 16,
    parameter int LANES = 4,
    parameter int ACC_W = 48,
    parameter int CNT_W = 16
);
    logic                   active;
    logic                   in_ready;
    logic [CNT_W-1:0]       vec_len;
    logic [LANES*DW-1:0]    data_a;
    logic [LANES*DW-1:0]    data_b;
    logic                   rd_en;
    logic                   out_empty;
    logic                   out_full;
    logic [ACC_W-1:0]       out_data;

    modport master (
        output active, vec_len, data_a, data_b, rd_en,
        input  in_ready, out_empty, out_full, out_data
    );

    modport slave (
        input  active, vec_len, data_a, data_b, rd_en,
        output in_ready, out_empty, out_full, out_data
    );
endinterface

// File: rtl/pe_out_fifo.sv
// ----------------------------------------------------------------------------
// pe_out_fifo
//   Synchronous first-word-fall-through FIFO for finished dot products.
//   Ports: clk, rst_n (async active-low), wr_en/din (push), rd_en (pop),
//          dout (head, 0 while empty), empty, full.
//   Pointers carry one extra wrap bit to tell full from empty. A push while
//   full is accepted only when a pop frees the head slot on the same edge;
//   a pop while empty is ignored.
// ----------------------------------------------------------------------------
module pe_out_fifo #(
    parameter int WIDTH = 48,
    parameter int DEPTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             wr_en,
    input  logic [WIDTH-1:0] din,
    input  logic             rd_en,
    output logic [WIDTH-1:0] dout,
    output logic             empty,
    output logic             full
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW:0]      wr_ptr;
    logic [AW:0]      rd_ptr;
    logic             do_pop;
    logic             do_push;

    assign empty   = (wr_ptr == rd_ptr);
    assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign do_pop  = rd_en && !empty;
    assign do_push = wr_en && (!full || do_pop);
    assign dout    = empty ? '0 : mem[rd_ptr[AW-1:0]];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
        end
    end

    // Storage is never read while empty, so it needs no reset.
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr[AW-1:0]] <= din;
    end
endmodule

// File: rtl/pe_vector_mac.sv
// ----------------------------------------------------------------------------
// pe_vector_mac
//   Multi-lane signed dot-product engine. Each accepted beat contributes
//   sum_i a_i*b_i; vec_len beats (0 treated as 1, sampled on the first beat)
//   form one result, which is pushed into an internal FWFT FIFO.
//   Ports:
//     clk, rst_n      clock, asynchronous active-low reset
//     bus (slave)     active/in_ready beat handshake, vec_len, data_a, data_b,
//                     rd_en/out_empty/out_full/out_data result FIFO port
//     busy            FSM not idle
//     overflow        sticky clamp flag (saturating build only, else 0)
//   Build option: define PE_SATURATE_EN for clamped accumulation with a
//   sticky overflow flag; otherwise the accumulator wraps mod 2^ACC_W.
//   ACC_W must stay <= 63 in the saturating build.
// ----------------------------------------------------------------------------
module pe_vector_mac
    import pe_pkg::*;
#(
    parameter int DW     = PE_DW,
    parameter int LANES  = PE_LANES,
    parameter int ACC_W  = PE_ACC_W,
    parameter int CNT_W  = 16,
    parameter int FIFO_D = 8
) (
    input  logic           clk,
    input  logic           rst_n,
    pe_vector_mac_if.slave bus,
    output logic           busy,
    output logic           overflow
);
    localparam int PW = 2 * DW + $clog2(LANES);

    pe_state_t               state_q, state_d;
    logic signed [ACC_W-1:0] acc_q, acc_d;
    logic [CNT_W-1:0]        cnt_q, cnt_d;
    logic [CNT_W-1:0]        len_q, len_d;
    logic signed [2*DW-1:0]  prod [LANES];
    logic signed [PW-1:0]    beat_sum;
    logic signed [ACC_W-1:0] beat_ext;
    logic signed [ACC_W-1:0] acc_sum;
    logic                    accept;
    logic                    fifo_wr;
    logic                    fifo_full;

    // Lane multipliers: full-precision signed products.
    for (genvar gi = 0; gi < LANES; gi++) begin : g_lane
        logic signed [DW-1:0] la;
        logic signed [DW-1:0] lb;
        assign la       = bus.data_a[gi*DW +: DW];
        assign lb       = bus.data_b[gi*DW +: DW];
        assign prod[gi] = (2*DW)'(la) * (2*DW)'(lb);
    end

    // Adder tree: PW bits holds LANES worst-case products without overflow.
    always_comb begin
        beat_sum = '0;
        for (int i = 0; i < LANES; i++)
            beat_sum = beat_sum + PW'(prod[i]);
    end

    assign beat_ext = ACC_W'(beat_sum);

`ifdef PE_SATURATE_EN
    logic signed [63:0] wide_sum;
    logic signed [63:0] sat_sum;
    logic               clamp;
    logic               ovf_q;

    assign wide_sum = 64'(acc_q) + 64'(beat_ext);
    assign sat_sum  = sat_add(64'(acc_q), 64'(beat_ext), ACC_W);
    assign acc_sum  = ACC_W'(sat_sum);
    assign clamp    = (sat_sum != wide_sum);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            ovf_q <= 1'b0;
        else if (state_q == PE_ACCUM && accept && clamp)
            ovf_q <= 1'b1;
    end

    assign overflow = ovf_q;
`else
    assign acc_sum  = acc_q + beat_ext;
    assign overflow = 1'b0;
`endif

    assign bus.in_ready = (state_q != PE_PUSH);
    assign busy         = (state_q != PE_IDLE);
    assign accept       = bus.active && bus.in_ready;

    always_comb begin
        state_d = state_q;
        acc_d   = acc_q;
        cnt_d   = cnt_q;
        len_d   = len_q;
        fifo_wr = 1'b0;
        case (state_q)
            PE_IDLE: begin
                if (accept) begin
                    len_d   = (bus.vec_len == '0) ? CNT_W'(1) : bus.vec_len;
                    acc_d   = beat_ext;
                    cnt_d   = CNT_W'(1);
                    state_d = (len_d == CNT_W'(1)) ? PE_PUSH : PE_ACCUM;
                end
            end
            PE_ACCUM: begin
                if (accept) begin
                    acc_d = acc_sum;
                    cnt_d = cnt_q + CNT_W'(1);
                    if (cnt_d == len_q) state_d = PE_PUSH;
                end
            end
            PE_PUSH: begin
                // A full FIFO still takes the result if the head pops this edge.
                if (!fifo_full || bus.rd_en) begin
                    fifo_wr = 1'b1;
                    acc_d   = '0;
                    cnt_d   = '0;
                    state_d = PE_IDLE;
                end
            end
            default: state_d = PE_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= PE_IDLE;
            acc_q   <= '0;
            cnt_q   <= '0;
            len_q   <= '0;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            cnt_q   <= cnt_d;
            len_q   <= len_d;
        end
    end

    pe_out_fifo #(
        .WIDTH (ACC_W),
        .DEPTH (FIFO_D)
    ) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .wr_en (fifo_wr),
        .din   (acc_q),
        .rd_en (bus.rd_en),
        .dout  (bus.out_data),
        .empty (bus.out_empty),
        .full  (fifo_full)
    );

    assign bus.out_full = fifo_full;
endmodule

// File: tb/tb_pe_vector_mac.sv
// ----------------------------------------------------------------------------
// tb_pe_vector_mac
//   Scoreboard bench for pe_vector_mac. Expected dot products are computed
//   from the driven beats and queued; they are compared as results leave
//   the FIFO. Honours PE_SATURATE_EN for the expected arithmetic.
// ----------------------------------------------------------------------------
module tb_pe_vector_mac;
    localparam int DW     = 16;
    localparam int LANES  = 4;
    localparam int ACC_W  = 48;
    localparam int CNT_W  = 16;
    localparam int FIFO_D = 8;
    localparam int BW     = LANES * DW;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic busy;
    logic overflow;

    pe_vector_mac_if #(.DW(DW), .LANES(LANES), .ACC_W(ACC_W), .CNT_W(CNT_W)) bus ();

    pe_vector_mac #(
        .DW(DW), .LANES(LANES), .ACC_W(ACC_W), .CNT_W(CNT_W), .FIFO_D(FIFO_D)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .bus      (bus),
        .busy     (busy),
        .overflow (overflow)
    );

    always #5 clk = ~clk;

    int     checks = 0;
    int     errors = 0;
    longint exp_q[$];

`ifdef PE_SATURATE_EN
    localparam longint MAXV = (64'sd1 <<< (ACC_W - 1)) - 64'sd1;
    localparam longint MINV = -MAXV - 64'sd1;
`endif

    function automatic longint lane_sum(input logic [BW-1:0] a, input logic [BW-1:0] b);
        longint s;
        s = 0;
        for (int i = 0; i < LANES; i++)
            s += longint'($signed(a[i*DW +: DW])) * longint'($signed(b[i*DW +: DW]));
        return s;
    endfunction

    function automatic longint model_add(input longint acc, input longint beat);
        longint s;
        s = acc + beat;
`ifdef PE_SATURATE_EN
        if (s > MAXV) s = MAXV;
        if (s < MINV) s = MINV;
`else
        s = (s <<< (64 - ACC_W)) >>> (64 - ACC_W);
`endif
        return s;
    endfunction

    // Present one beat and hold it until the DUT accepts it (bounded).
    task automatic drive_beat(input logic [BW-1:0] a, input logic [BW-1:0] b,
                              input logic [CNT_W-1:0] len);
        bit ok;
        ok = 1'b0;
        bus.active  = 1'b1;
        bus.data_a  = a;
        bus.data_b  = b;
        bus.vec_len = len;
        for (int t = 0; t < 64 && !ok; t++) begin
            if (bus.in_ready) ok = 1'b1;
            @(posedge clk); #1;
        end
        bus.active = 1'b0;
        if (!ok) begin
            checks++;
            errors++;
            $display("FAIL beat_accept timeout: in_ready stayed %0b, required 1", bus.in_ready);
        end
    endtask

    // Random vector; later beats may carry a bogus vec_len that must be ignored.
    task automatic send_rand_vector(input int len, input bit jitter_len);
        longint acc;
        int     n;
        logic [BW-1:0] a;
        logic [BW-1:0] b;
        acc = 0;
        n = (len == 0) ? 1 : len;
        for (int i = 0; i < n; i++) begin
            a = {$urandom, $urandom};
            b = {$urandom, $urandom};
            acc = model_add(acc, lane_sum(a, b));
            drive_beat(a, b, (i == 0 || !jitter_len) ? CNT_W'(len) : CNT_W'(1));
        end
        exp_q.push_back(acc);
    endtask

    task automatic pop_head(output logic [ACC_W-1:0] got);
        got = bus.out_data;
        bus.rd_en = 1'b1;
        @(posedge clk); #1;
        bus.rd_en = 1'b0;
    endtask

    task automatic test_reset();
        bus.active = 1'b0; bus.rd_en = 1'b0; bus.vec_len = '0;
        bus.data_a = '0;   bus.data_b = '0;
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        checks++; if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready got %0b want 1", bus.in_ready); end
        checks++; if (bus.out_empty !== 1'b1) begin errors++; $display("FAIL reset_out_empty got %0b want 1", bus.out_empty); end
        checks++; if (bus.out_full !== 1'b0) begin errors++; $display("FAIL reset_out_full got %0b want 0", bus.out_full); end
        checks++; if (bus.out_data !== '0) begin errors++; $display("FAIL reset_out_data got %0d want 0", bus.out_data); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %0b want 0", busy); end
        checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL reset_overflow got %0b want 0", overflow); end
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_basic();
        logic [ACC_W-1:0] got;
        exp_q.push_back(30);
        drive_beat({16'd4, 16'd3, 16'd2, 16'd1}, {16'd1, 16'd1, 16'd1, 16'd1}, 16'd2);
        drive_beat({16'd1, 16'd1, 16'd1, 16'd1}, {16'd5, 16'd5, 16'd5, 16'd5}, 16'd2);
        checks++; if (bus.out_empty !== 1'b1) begin errors++; $display("FAIL basic_latency_empty got %0b want 1", bus.out_empty); end
        checks++; if (bus.in_ready !== 1'b0) begin errors++; $display("FAIL basic_push_in_ready got %0b want 0", bus.in_ready); end
        @(posedge clk); #1;
        checks++; if (bus.out_empty !== 1'b0) begin errors++; $display("FAIL basic_out_empty got %0b want 0", bus.out_empty); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL basic_busy got %0b want 0", busy); end
        pop_head(got);
        checks++; if (got !== ACC_W'(exp_q.pop_front())) begin errors++; $display("FAIL basic_result got %0d want 30", $signed(got)); end
    endtask

    task automatic test_len_zero();
        logic [ACC_W-1:0] got;
        exp_q.push_back(-21);
        drive_beat({16'd0, 16'd0, 16'd0, -16'sd3}, {16'd0, 16'd0, 16'd0, 16'd7}, 16'd0);
        @(posedge clk); #1;
        checks++; if (bus.out_empty !== 1'b0) begin errors++; $display("FAIL len0_out_empty got %0b want 0", bus.out_empty); end
        pop_head(got);
        checks++; if (got !== ACC_W'(exp_q.pop_front())) begin errors++; $display("FAIL len0_result got %0d want -21", $signed(got)); end
    endtask

    task automatic test_full_backpressure();
        logic [ACC_W-1:0] got;
        logic [ACC_W-1:0] want;
        for (int k = 0; k < FIFO_D; k++) begin
            send_rand_vector(1, 1'b0);
            @(posedge clk); #1;
        end
        checks++; if (bus.out_full !== 1'b1) begin errors++; $display("FAIL full_after_8 got %0b want 1", bus.out_full); end
        send_rand_vector(1, 1'b0);
        repeat (3) begin @(posedge clk); #1; end
        checks++; if (bus.in_ready !== 1'b0) begin errors++; $display("FAIL full_hold_in_ready got %0b want 0", bus.in_ready); end
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL full_hold_busy got %0b want 1", busy); end
        want = ACC_W'(exp_q.pop_front());
        pop_head(got);
        checks++; if (got !== want) begin errors++; $display("FAIL full_head got %0d want %0d", $signed(got), $signed(want)); end
        checks++; if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL full_release_in_ready got %0b want 1", bus.in_ready); end
        checks++; if (bus.out_full !== 1'b1) begin errors++; $display("FAIL full_swap_out_full got %0b want 1", bus.out_full); end
        for (int k = 0; k < FIFO_D; k++) begin
            want = ACC_W'(exp_q.pop_front());
            pop_head(got);
            checks++; if (got !== want) begin errors++; $display("FAIL full_drain_%0d got %0d want %0d", k, $signed(got), $signed(want)); end
        end
        checks++; if (bus.out_empty !== 1'b1) begin errors++; $display("FAIL full_drained_empty got %0b want 1", bus.out_empty); end
    endtask

    task automatic test_reset_mid_vector();
        logic [ACC_W-1:0] got;
        logic [ACC_W-1:0] want;
        send_rand_vector(1, 1'b0);
        @(posedge clk); #1;
        checks++; if (bus.out_empty !== 1'b0) begin errors++; $display("FAIL rstmid_pre_empty got %0b want 0", bus.out_empty); end
        exp_q.delete();
        for (int i = 0; i < 3; i++)
            drive_beat({$urandom, $urandom}, {$urandom, $urandom}, 16'd5);
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL rstmid_busy_before got %0b want 1", busy); end
        rst_n = 1'b0;
        #1;
        checks++; if (bus.out_empty !== 1'b1) begin errors++; $display("FAIL rstmid_out_empty got %0b want 1", bus.out_empty); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rstmid_busy got %0b want 0", busy); end
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk); #1;
        send_rand_vector(2, 1'b0);
        checks++; if (bus.out_empty !== 1'b1) begin errors++; $display("FAIL rstmid_fresh_latency got %0b want 1", bus.out_empty); end
        @(posedge clk); #1;
        want = ACC_W'(exp_q.pop_front());
        pop_head(got);
        checks++; if (got !== want) begin errors++; $display("FAIL rstmid_fresh_result got %0d want %0d", $signed(got), $signed(want)); end
    endtask

    task automatic test_empty_read();
        logic [ACC_W-1:0] got;
        logic [ACC_W-1:0] want;
        bus.rd_en = 1'b1;
        repeat (3) begin @(posedge clk); #1; end
        bus.rd_en = 1'b0;
        checks++; if (bus.out_empty !== 1'b1) begin errors++; $display("FAIL emptyrd_still_empty got %0b want 1", bus.out_empty); end
        send_rand_vector(1, 1'b0);
        @(posedge clk); #1;
        checks++; if (bus.out_empty !== 1'b0) begin errors++; $display("FAIL emptyrd_after_push got %0b want 0", bus.out_empty); end
        want = ACC_W'(exp_q.pop_front());
        pop_head(got);
        checks++; if (got !== want) begin errors++; $display("FAIL emptyrd_result got %0d want %0d", $signed(got), $signed(want)); end
        checks++; if (bus.out_empty !== 1'b1) begin errors++; $display("FAIL emptyrd_final_empty got %0b want 1", bus.out_empty); end
    endtask

    task automatic test_back_to_back();
        logic [ACC_W-1:0] got;
        logic [ACC_W-1:0] want;
        send_rand_vector(3, 1'b1);
        send_rand_vector(3, 1'b1);
        @(posedge clk); #1;
        for (int k = 0; k < 2; k++) begin
            want = ACC_W'(exp_q.pop_front());
            pop_head(got);
            checks++; if (got !== want) begin errors++; $display("FAIL b2b_result_%0d got %0d want %0d", k, $signed(got), $signed(want)); end
        end
        checks++; if (bus.out_empty !== 1'b1) begin errors++; $display("FAIL b2b_final_empty got %0b want 1", bus.out_empty); end
    endtask

    task automatic test_extreme_accumulate();
        logic [ACC_W-1:0] got;
        logic [ACC_W-1:0] want;
        longint acc;
        logic   want_ovf;
        logic [BW-1:0] v;
        v = {LANES{16'h8000}};
        acc = 0;
        for (int i = 0; i < 65535; i++)
            acc = model_add(acc, lane_sum(v, v));
        exp_q.push_back(acc);
`ifdef PE_SATURATE_EN
        want_ovf = 1'b1;
`else
        want_ovf = 1'b0;
`endif
        bus.data_a  = v;
        bus.data_b  = v;
        bus.vec_len = 16'hFFFF;
        bus.active  = 1'b1;
        repeat (65535) @(posedge clk);
        #1;
        bus.active = 1'b0;
        checks++; if (busy !== 1'b1 || bus.in_ready !== 1'b0) begin errors++; $display("FAIL big_push_state busy %0b in_ready %0b want 1 0", busy, bus.in_ready); end
        @(posedge clk); #1;
        checks++; if (overflow !== want_ovf) begin errors++; $display("FAIL big_overflow got %0b want %0b", overflow, want_ovf); end
        want = ACC_W'(exp_q.pop_front());
        pop_head(got);
        checks++; if (got !== want) begin errors++; $display("FAIL big_result got %0d want %0d", $signed(got), $signed(want)); end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_len_zero();
        test_full_backpressure();
        test_reset_mid_vector();
        test_empty_read();
        test_back_to_back();
        test_extreme_accumulate();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
